// File: rtl/fp_operand_unpacker.sv
// rtl/fp_operand_unpacker.sv - two-stage IEEE754 single-precision operand decoder feeding an FP adder
module fp_operand_unpacker #(
    parameter int FLUSH_SUBNORMAL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_num1,
    input  logic [31:0] in_num2,
    input  logic        in_add_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] num1,
    output logic [31:0] num2,
    output logic [7:0]  exp_num1,
    output logic [7:0]  exp_num2,
    output logic        sign_num1,
    output logic        sign_num2,
    output logic [22:0] mantissa_num1,
    output logic [22:0] mantissa_num2,
    output logic        normilized_bit_num1,
    output logic        normilized_bit_num2,
    output logic        add_sub,
    output logic [2:0]  class_num1,
    output logic [2:0]  class_num2,
    output logic        special_valid,
    output logic [31:0] special_result
);
    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_SUB  = 3'd1;
    localparam logic [2:0] CLS_NORM = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_QNAN = 3'd4;
    localparam logic [2:0] CLS_SNAN = 3'd5;
    localparam logic [31:0] CANON_NAN = 32'h7FC00000;

    typedef struct packed {
        logic [2:0]  cls;
        logic        nbit;
        logic [7:0]  exp;
        logic [22:0] mant;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] v);
        dec_t d;
        d = '0;
        if (v[30:23] == 8'h00) begin
            if (v[22:0] != 23'd0 && FLUSH_SUBNORMAL == 0) begin
                d.cls  = CLS_SUB;
                d.exp  = 8'd1;
                d.mant = v[22:0];
            end
        end else if (v[30:23] == 8'hFF) begin
            d.exp  = 8'hFF;
            d.nbit = 1'b1;
            d.mant = v[22:0];
            if (v[22:0] == 23'd0)
                d.cls = CLS_INF;
            else if (v[22])
                d.cls = CLS_QNAN;
            else
                d.cls = CLS_SNAN;
        end else begin
            d.cls  = CLS_NORM;
            d.exp  = v[30:23];
            d.nbit = 1'b1;
            d.mant = v[22:0];
        end
        return d;
    endfunction

    logic        s1_valid;
    logic [31:0] s1_num1;
    logic [31:0] s1_num2;
    logic        s1_add_sub;
    logic        s2_load;

    dec_t        d1;
    dec_t        d2;
    logic        nan_any;
    logic        inf1;
    logic        inf2;
    logic        eff_sign2;
    logic        spec_v;
    logic [31:0] spec_r;

    assign in_ready = !s1_valid | (!out_valid | out_ready);
    assign s2_load  = s1_valid & (!out_valid | out_ready);

    // Special-operand bypass is computed from S1 so it lands in S2 alongside the decoded fields.
    always_comb begin
        d1        = decode(s1_num1);
        d2        = decode(s1_num2);
        nan_any   = (d1.cls == CLS_QNAN) || (d1.cls == CLS_SNAN) ||
                    (d2.cls == CLS_QNAN) || (d2.cls == CLS_SNAN);
        inf1      = (d1.cls == CLS_INF);
        inf2      = (d2.cls == CLS_INF);
        eff_sign2 = s1_num2[31] ^ s1_add_sub;
        spec_v    = 1'b0;
        spec_r    = 32'd0;
        if (nan_any || (inf1 && inf2 && (s1_num1[31] != eff_sign2))) begin
            spec_v = 1'b1;
            spec_r = CANON_NAN;
        end else if (inf1) begin
            spec_v = 1'b1;
            spec_r = {s1_num1[31], 8'hFF, 23'd0};
        end else if (inf2) begin
            spec_v = 1'b1;
            spec_r = {eff_sign2, 8'hFF, 23'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_num1    <= 32'd0;
            s1_num2    <= 32'd0;
            s1_add_sub <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_num1    <= in_num1;
                s1_num2    <= in_num2;
                s1_add_sub <= in_add_sub;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid           <= 1'b0;
            num1                <= 32'd0;
            num2                <= 32'd0;
            exp_num1            <= 8'd0;
            exp_num2            <= 8'd0;
            sign_num1           <= 1'b0;
            sign_num2           <= 1'b0;
            mantissa_num1       <= 23'd0;
            mantissa_num2       <= 23'd0;
            normilized_bit_num1 <= 1'b0;
            normilized_bit_num2 <= 1'b0;
            add_sub             <= 1'b0;
            class_num1          <= 3'd0;
            class_num2          <= 3'd0;
            special_valid       <= 1'b0;
            special_result      <= 32'd0;
        end else if (s2_load) begin
            out_valid           <= 1'b1;
            num1                <= s1_num1;
            num2                <= s1_num2;
            exp_num1            <= d1.exp;
            exp_num2            <= d2.exp;
            sign_num1           <= s1_num1[31];
            sign_num2           <= s1_num2[31];
            mantissa_num1       <= d1.mant;
            mantissa_num2       <= d2.mant;
            normilized_bit_num1 <= d1.nbit;
            normilized_bit_num2 <= d2.nbit;
            add_sub             <= s1_add_sub;
            class_num1          <= d1.cls;
            class_num2          <= d2.cls;
            special_valid       <= spec_v;
            special_result      <= spec_r;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
